// File: rtl/tracer_recip_serial.sv
// Signed fixed-point reciprocal with serial operand load and serial result drain.
// 1/x by MSB-first restoring division, then optional |.| and saturation to +/-max.
module tracer_recip_serial #(
    parameter int unsigned INT_BITS  = 6,
    parameter int unsigned FRAC_BITS = 10,
    parameter int unsigned NIB       = 4,
    parameter int unsigned OUT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [NIB-1:0]   i_data,
    input  logic             i_abs,
    output logic             o_in_ready,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_data,
    output logic             o_last,
    output logic             o_sat,
    input  logic             i_out_ready,
    output logic             o_busy
);

    localparam int unsigned W      = INT_BITS + FRAC_BITS;
    localparam int unsigned N_IN   = W / NIB;
    localparam int unsigned N_OUT  = W / OUT_W;
    localparam int unsigned QW     = 2 * FRAC_BITS + 1;
    localparam int unsigned RW     = W + 2;
    localparam int unsigned CMP_W  = (QW > W) ? QW : W;
    localparam int unsigned IN_CW  = $clog2(N_IN + 1);
    localparam int unsigned OUT_CW = $clog2(N_OUT + 1);
    localparam int unsigned DIV_CW = $clog2(QW + 1);

    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_EMIT = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [W-1:0]      operand;
    logic              abs_q;
    logic [IN_CW-1:0]  in_cnt;
    logic [DIV_CW-1:0] div_cnt;
    logic [QW-1:0]     quot;
    logic [RW-1:0]     rem;
    logic [W-1:0]      shifter;
    logic [OUT_CW-1:0] out_idx;

    logic              load_done;
    logic              div_done;
    logic              emit_done;
    logic [W-1:0]      op_abs;
    logic [W:0]        mag;
    logic [RW-1:0]     rem_shift;
    logic [RW-1:0]     rem_sub;
    logic              ge;
    logic              sat;
    logic [W-1:0]      r_mag;
    logic [W-1:0]      result;

    assign load_done = (in_cnt == IN_CW'(N_IN - 1));
    assign div_done  = (div_cnt == DIV_CW'(QW - 1));
    assign emit_done = (out_idx == OUT_CW'(N_OUT - 1));
    assign o_data    = shifter[W-1 -: OUT_W];

    // Magnitude is W+1 bits wide so the most negative operand keeps its value.
    always_comb begin
        op_abs    = operand[W-1] ? (~operand + W'(1)) : operand;
        mag       = {1'b0, op_abs};
        // Dividend is 2^(2F): its only set bit enters on the first step.
        rem_shift = {rem[RW-2:0], (div_cnt == '0)};
        ge        = (rem_shift >= RW'(mag));
        rem_sub   = rem_shift - RW'(mag);
        sat       = (mag == '0) || (CMP_W'(quot) > CMP_W'(MAX_POS));
        r_mag     = sat ? MAX_POS : W'(quot);
        result    = (operand[W-1] && !abs_q) ? (~r_mag + W'(1)) : r_mag;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_LOAD:  if (i_valid && load_done) state_next = S_DIV;
            S_DIV:   if (div_done) state_next = S_FIX;
            S_FIX:   state_next = S_EMIT;
            S_EMIT:  if (i_out_ready && emit_done) state_next = S_LOAD;
            default: state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_LOAD;
        else       state <= state_next;
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            operand    <= '0;
            abs_q      <= 1'b0;
            in_cnt     <= '0;
            div_cnt    <= '0;
            quot       <= '0;
            rem        <= '0;
            shifter    <= '0;
            out_idx    <= '0;
            o_in_ready <= 1'b1;
            o_busy     <= 1'b0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_sat      <= 1'b0;
        end else begin
            o_in_ready <= (state_next == S_LOAD);
            o_busy     <= (state_next != S_LOAD);
            o_valid    <= (state_next == S_EMIT);
            case (state)
                S_LOAD: begin
                    if (i_valid) begin
                        operand <= W'({operand, i_data});
                        if (load_done) begin
                            in_cnt  <= '0;
                            abs_q   <= i_abs;
                            div_cnt <= '0;
                            rem     <= '0;
                            quot    <= '0;
                        end else begin
                            in_cnt <= in_cnt + IN_CW'(1);
                        end
                    end
                end
                S_DIV: begin
                    rem     <= ge ? rem_sub : rem_shift;
                    quot    <= QW'({quot, ge});
                    div_cnt <= div_cnt + DIV_CW'(1);
                end
                S_FIX: begin
                    shifter <= result;
                    o_sat   <= sat;
                    out_idx <= '0;
                    o_last  <= (N_OUT == 1);
                end
                S_EMIT: begin
                    if (i_out_ready) begin
                        shifter <= W'({shifter, {OUT_W{1'b0}}});
                        if (emit_done) begin
                            out_idx <= '0;
                            o_last  <= 1'b0;
                        end else begin
                            out_idx <= out_idx + OUT_CW'(1);
                            o_last  <= ((out_idx + OUT_CW'(1)) == OUT_CW'(N_OUT - 1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tracer_recip_serial.sv
// Self-checking bench for tracer_recip_serial: directed table, corner sequences, random vs model.
module tb_tracer_recip_serial;

    localparam int unsigned INT_BITS  = 6;
    localparam int unsigned FRAC_BITS = 10;
    localparam int unsigned NIB       = 4;
    localparam int unsigned OUT_W     = 8;
    localparam int unsigned W         = INT_BITS + FRAC_BITS;
    localparam int unsigned N_IN      = W / NIB;
    localparam int unsigned N_OUT     = W / OUT_W;
    localparam int          LAT       = 2 * FRAC_BITS + 2;
    localparam longint      MAXV      = (longint'(1) << (W - 1)) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             i_valid;
    logic [NIB-1:0]   i_data;
    logic             i_abs;
    logic             o_in_ready;
    logic             o_valid;
    logic [OUT_W-1:0] o_data;
    logic             o_last;
    logic             o_sat;
    logic             i_out_ready;
    logic             o_busy;

    int vectors = 0;
    int errors  = 0;

    tracer_recip_serial #(
        .INT_BITS (INT_BITS),
        .FRAC_BITS(FRAC_BITS),
        .NIB      (NIB),
        .OUT_W    (OUT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .i_abs      (i_abs),
        .o_in_ready (o_in_ready),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_last     (o_last),
        .o_sat      (o_sat),
        .i_out_ready(i_out_ready),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x;
        bit           ab;
        bit           gap;
        logic [W-1:0] res;
        bit           sat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: 1/x with plain integer arithmetic.
    function automatic void model(input logic [W-1:0] x, input bit ab,
                                  output logic [W-1:0] res, output bit sat);
        longint xi, m, q, r;
        xi = longint'($signed(x));
        m  = (xi < 0) ? -xi : xi;
        if (m == 0) begin
            sat = 1'b1;
            r   = MAXV;
        end else begin
            q   = (longint'(1) << (2 * FRAC_BITS)) / m;
            sat = (q > MAXV);
            r   = sat ? MAXV : q;
        end
        if (xi < 0 && !ab) r = -r;
        res = W'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_in_ready"}, 32'(o_in_ready), 32'd1);
        check({tag, "_valid"},    32'(o_valid),    32'd0);
        check({tag, "_data"},     32'(o_data),     32'd0);
        check({tag, "_last"},     32'(o_last),     32'd0);
        check({tag, "_sat"},      32'(o_sat),      32'd0);
        check({tag, "_busy"},     32'(o_busy),     32'd0);
    endtask

    task automatic send(input logic [W-1:0] x, input bit ab, input bit gapped);
        logic [W-1:0] tmp;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (gapped && i > 0) begin
                i_valid = 1'b0;
                i_data  = NIB'($urandom);
                i_abs   = 1'($urandom);
                tick();
            end
            tmp     = x << (NIB * i);
            i_valid = 1'b1;
            i_data  = tmp[W-1 -: NIB];
            i_abs   = ab;
            tick();
        end
        i_valid = 1'b0;
        i_abs   = 1'($urandom);
        check("busy_after_load",     32'(o_busy),     32'd1);
        check("in_ready_after_load", 32'(o_in_ready), 32'd0);
    endtask

    // Garbage on the input bus while busy must be ignored.
    task automatic wait_valid();
        int cnt = 0;
        while (!o_valid && cnt < LAT + 10) begin
            i_valid = 1'($urandom);
            i_data  = NIB'($urandom);
            tick();
            cnt++;
        end
        i_valid = 1'b0;
        check("latency", 32'(cnt), 32'(LAT));
    endtask

    task automatic collect(input logic [W-1:0] exp, input bit exp_sat, input bit rand_ready);
        int k = 0;
        int guard = 0;
        logic [W-1:0] tmp;
        check("sat", 32'(o_sat), 32'(exp_sat));
        while (k < int'(N_OUT) && guard < 200) begin
            i_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            i_valid     = 1'($urandom);
            i_data      = NIB'($urandom);
            check("valid_in_emit", 32'(o_valid), 32'd1);
            if (i_out_ready) begin
                tmp = exp << (OUT_W * k);
                check("chunk", 32'(o_data), 32'(tmp[W-1 -: OUT_W]));
                check("last",  32'(o_last), 32'(k == int'(N_OUT) - 1));
                k++;
            end
            tick();
            guard++;
        end
        i_valid = 1'b0;
        check("chunks_done",    32'(k),          32'(N_OUT));
        check("in_ready_after", 32'(o_in_ready), 32'd1);
        check("valid_after",    32'(o_valid),    32'd0);
        check("busy_after",     32'(o_busy),     32'd0);
        check("last_after",     32'(o_last),     32'd0);
        check("sat_hold",       32'(o_sat),      32'(exp_sat));
    endtask

    task automatic run_op(input logic [W-1:0] x, input bit ab, input bit gapped,
                          input bit rand_ready, input logic [W-1:0] exp, input bit exp_sat);
        i_out_ready = 1'b1;
        send(x, ab, gapped);
        wait_valid();
        collect(exp, exp_sat, rand_ready);
    endtask

    initial begin
        logic [W-1:0] rx, rres;
        bit           rab, rsat;

        vecs[0]  = '{x: 16'h0400, ab: 1'b0, gap: 1'b0, res: 16'h0400, sat: 1'b0};
        vecs[1]  = '{x: 16'h0200, ab: 1'b0, gap: 1'b0, res: 16'h0800, sat: 1'b0};
        vecs[2]  = '{x: 16'hF400, ab: 1'b0, gap: 1'b0, res: 16'hFEAB, sat: 1'b0};
        vecs[3]  = '{x: 16'hF400, ab: 1'b1, gap: 1'b0, res: 16'h0155, sat: 1'b0};
        vecs[4]  = '{x: 16'h0021, ab: 1'b0, gap: 1'b0, res: 16'h7C1F, sat: 1'b0};
        vecs[5]  = '{x: 16'h0000, ab: 1'b0, gap: 1'b0, res: 16'h7FFF, sat: 1'b1};
        vecs[6]  = '{x: 16'h0001, ab: 1'b0, gap: 1'b0, res: 16'h7FFF, sat: 1'b1};
        vecs[7]  = '{x: 16'hFFF0, ab: 1'b0, gap: 1'b0, res: 16'h8001, sat: 1'b1};
        vecs[8]  = '{x: 16'h8000, ab: 1'b0, gap: 1'b0, res: 16'hFFE0, sat: 1'b0};
        vecs[9]  = '{x: 16'h0020, ab: 1'b0, gap: 1'b0, res: 16'h7FFF, sat: 1'b1};
        vecs[10] = '{x: 16'hFFF0, ab: 1'b1, gap: 1'b0, res: 16'h7FFF, sat: 1'b1};
        vecs[11] = '{x: 16'h0400, ab: 1'b0, gap: 1'b1, res: 16'h0400, sat: 1'b0};
        vecs[12] = '{x: 16'hF400, ab: 1'b0, gap: 1'b1, res: 16'hFEAB, sat: 1'b0};

        reset       = 1'b1;
        i_valid     = 1'b0;
        i_data      = '0;
        i_abs       = 1'b0;
        i_out_ready = 1'b1;
        tick();
        tick();
        reset_check("por");
        reset = 1'b0;
        tick();

        foreach (vecs[i])
            run_op(vecs[i].x, vecs[i].ab, vecs[i].gap, 1'b0, vecs[i].res, vecs[i].sat);

        // Backpressure: first chunk must hold while downstream stalls.
        i_out_ready = 1'b0;
        send(16'h0400, 1'b0, 1'b0);
        wait_valid();
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(o_valid), 32'd1);
            check("bp_data",  32'(o_data),  32'h04);
            check("bp_last",  32'(o_last),  32'd0);
            tick();
        end
        collect(16'h0400, 1'b0, 1'b0);

        // Reset mid-load: partial operand is discarded.
        i_valid = 1'b1;
        i_data  = 4'hF;
        tick();
        tick();
        i_valid = 1'b0;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
        reset_check("rst_load");
        run_op(16'h0800, 1'b0, 1'b0, 1'b0, 16'h0200, 1'b0);

        // Reset mid-division after a saturating result set o_sat.
        run_op(16'h0000, 1'b0, 1'b0, 1'b0, 16'h7FFF, 1'b1);
        send(16'h0400, 1'b0, 1'b0);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        reset_check("rst_div");
        run_op(16'h0800, 1'b0, 1'b0, 1'b0, 16'h0200, 1'b0);

        // Reset mid-emit while the output is stalled.
        i_out_ready = 1'b0;
        send(16'h0000, 1'b0, 1'b0);
        wait_valid();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        reset_check("rst_emit");
        run_op(16'h0800, 1'b0, 1'b0, 1'b0, 16'h0200, 1'b0);

        // Random operands against the reference model.
        for (int n = 0; n < 40; n++) begin
            rx  = W'($urandom);
            if ($urandom_range(0, 3) == 0) rx = W'($signed(7'($urandom)));
            rab = 1'($urandom);
            model(rx, rab, rres, rsat);
            run_op(rx, rab, 1'($urandom), 1'b1, rres, rsat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/tracer_recip_serial.md
# tracer_recip_serial

Parametrised, multi-cycle signed fixed-point reciprocal unit for the ray-caster datapath, fed and drained over narrow serial buses. An operand arrives as NIB-bit chunks under a valid/ready handshake. The block computes 1/x by iterative restoring division, applies optional absolute-value and saturation, then streams the result out as OUT_W-bit chunks under a second valid/ready handshake. It is the sequential, width-generic successor to the fixed Q6.10 nibble-in/byte-out reciprocal front end.

## Interface
- INT_BITS, 6: integer bits of the signed Qm.n format, including the sign bit.
- FRAC_BITS, 10: fraction bits. W = INT_BITS+FRAC_BITS.
- NIB, 4: input chunk width. W must be a multiple of NIB.
- OUT_W, 8: output chunk width. W must be a multiple of OUT_W.
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- i_valid  in  1  input chunk present.
- i_data  in  NIB  input chunk, most-significant chunk first.
- i_abs  in  1  1 selects |1/x| (result forced non-negative). Sampled on the final input chunk.
- o_in_ready  out  1  block accepts an input chunk this cycle.
- o_valid  out  1  o_data holds a valid result chunk.
- o_data  out  OUT_W  result chunk, most-significant chunk first.
- o_last  out  1  current chunk is the final chunk of the result.
- o_sat  out  1  the last result was saturated.
- i_out_ready  in  1  downstream accepts the chunk this cycle.
- o_busy  out  1  the block is in DIV, FIX or EMIT.

## Operation
- States: LOAD → DIV → FIX → EMIT → LOAD.
- LOAD
  - o_in_ready=1.
  - Each cycle with i_valid=1 shifts the operand register left by NIB and inserts i_data.
  - After W/NIB accepted chunks, latch i_abs and go to DIV.
- DIV
  - Computes the magnitude M=|x| as a W+1-bit unsigned value, so x=-2^(W-1) is handled.
  - Computes Q = floor(2^(2·FRAC_BITS) / M) by restoring division, one quotient bit per cycle, MSB first, over 2·FRAC_BITS+1 cycles.
  - Operand register, quotient and remainder are internal.
- FIX (1 cycle)
  - sat=1 if M==0 or Q > 2^(W-1)-1.
  - Magnitude R = sat ? 2^(W-1)-1 : Q.
  - Result = −R (two's complement, W bits) if x<0 and latched abs=0; otherwise R.
  - Zero operand yields +max (0x7FFF for the defaults).
  - Negative saturation yields −max (0x8001 for the defaults).
  - Load the result into the output shifter, drive the top OUT_W bits onto o_data, update o_sat.
- EMIT
  - o_valid=1. A chunk transfers on a cycle with o_valid && i_out_ready; the shifter then advances by OUT_W.
  - o_last=1 while the chunk index is W/OUT_W−1.
  - Transfer of the last chunk returns to LOAD.
  - i_out_ready=0 holds o_data and o_last stable.
- Rounding: truncation toward zero of the magnitude, before the sign is applied.
- Inputs in states other than LOAD are ignored: o_in_ready=0, and i_valid/i_data have no effect.

## Timing
- Reset values: o_in_ready=1, o_valid=0, o_data=0, o_last=0, o_sat=0, o_busy=0. State LOAD, chunk counters 0, operand 0.
- Reset asserted in any state, including mid-load, mid-division or mid-emit, aborts the operation. Partial input is discarded and the next cycle is LOAD with the reset values above.
- Latency: the final input chunk is accepted at edge E0. DIV occupies edges E1..E(2F+1). FIX updates at edge E(2F+2), and o_valid is high starting from the cycle after that edge.
  - Defaults: o_valid rises 22 cycles after E0.
- Throughput with i_out_ready held at 1 and input always valid: W/NIB + 2F+2 + W/OUT_W cycles per operand (defaults: 4+22+2=28).
- o_in_ready rises in the cycle after the last output chunk transfers. There is no overlap of load and emit.
- o_sat holds its value from FIX until the next FIX or reset.
- o_busy=1 exactly when o_in_ready=0.

## Test plan
Defaults throughout (Q6.10, NIB=4, OUT_W=8).
- Load 0x0400 (1.0) with abs=0 → chunks 0x04, 0x00, o_last on the second chunk, o_sat=0. Also load 0x0200 (0.5) → result 0x0800.
- Load 0xF400 (−3.0) with abs=0 → 0xFEAB. Repeat with abs=1 → 0x0155. Load 0x0021 → 0x7C1F, sat=0, exercising truncation.
- Load 0x0000 → 0x7FFF, sat=1. Load 0x0001 → 0x7FFF, sat=1. Load 0xFFF0 (abs=0) → 0x8001, sat=1. Load 0x8000 (abs=0) → 0xFFE0, sat=0.
- Backpressure: hold i_out_ready=0 for 5 cycles after o_valid rises → o_data stays 0x04 and o_valid stays 1. Release → both chunks transfer in order and o_in_ready rises the cycle after.
- Gapped input: i_valid toggles 1,0,1,0,… across the 4 chunks → same result as contiguous input. Check that o_valid rises exactly 22 cycles after the final-chunk edge.
- Assert reset for 1 cycle mid-DIV, and again mid-EMIT → all outputs return to the reset values next cycle. A following clean load of 0x0800 returns 0x0200.
